// File: rtl/merge_2way.sv
// Two-way merge of sorted runs pulled from FIFOs A and B into one downstream
// FIFO. Each start merges exactly RUN_LEN elements from each side, emitting
// them in non-decreasing unsigned order; equal keys are taken from A first.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start, all handshakes idle
// MERGE    | both runs still have elements left; compare heads each cycle
// DRAIN_A  | run B finished, forward the remainder of run A
// DRAIN_B  | run A finished, forward the remainder of run B
// DONE     | one-cycle completion pulse, then back to IDLE
module merge_2way #(
    parameter int WIDTH   = 8,
    parameter int RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a_empty,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_pop_req_n,
    input  logic             b_empty,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_pop_req_n,
    input  logic             out_full,
    output logic             push_req_n,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    localparam int            CW      = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] RUN_END = CW'(RUN_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MERGE,
        S_DRAIN_A,
        S_DRAIN_B,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_a_q, cnt_a_d;
    logic [CW-1:0] cnt_b_q, cnt_b_d;
    logic [CW-1:0] cnt_a_inc, cnt_b_inc;
    logic          take_a, take_b;

    assign cnt_a_inc = cnt_a_q + CW'(1);
    assign cnt_b_inc = cnt_b_q + CW'(1);

    // State and per-side element counters; reset abandons any run in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    // Select the transfer source for this cycle and compute the next state.
    // A transfer only happens when its head is valid and downstream has room,
    // so a pop is always paired with a push in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        take_a  = 1'b0;
        take_b  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MERGE;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                end
            end
            S_MERGE: begin
                if (!a_empty && !b_empty && !out_full) begin
                    if (a_data <= b_data) begin
                        take_a  = 1'b1;
                        cnt_a_d = cnt_a_inc;
                        if (cnt_a_inc == RUN_END) state_d = S_DRAIN_B;
                    end else begin
                        take_b  = 1'b1;
                        cnt_b_d = cnt_b_inc;
                        if (cnt_b_inc == RUN_END) state_d = S_DRAIN_A;
                    end
                end
            end
            S_DRAIN_A: begin
                // The count guard keeps a run from ever over-popping its FIFO.
                if (!a_empty && !out_full && (cnt_a_q != RUN_END)) begin
                    take_a  = 1'b1;
                    cnt_a_d = cnt_a_inc;
                    if ((cnt_a_inc == RUN_END) && (cnt_b_q == RUN_END)) state_d = S_DONE;
                end
            end
            S_DRAIN_B: begin
                if (!b_empty && !out_full && (cnt_b_q != RUN_END)) begin
                    take_b  = 1'b1;
                    cnt_b_d = cnt_b_inc;
                    if ((cnt_b_inc == RUN_END) && (cnt_a_q == RUN_END)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs; data_out is held at zero whenever nothing is pushed.
    always_comb begin
        a_pop_req_n = ~take_a;
        b_pop_req_n = ~take_b;
        push_req_n  = ~(take_a | take_b);
        data_out    = '0;
        if (take_a)      data_out = a_data;
        else if (take_b) data_out = b_data;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_merge_2way.sv
// Directed bench for merge_2way: small FIFO models feed A and B, pushes are
// logged and compared against hand-written expected sequences.
module tb_merge_2way;

    localparam int W  = 8;
    localparam int RL = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         a_empty, b_empty, out_full;
    logic [W-1:0] a_data, b_data, data_out;
    logic         a_pop_req_n, b_pop_req_n, push_req_n, busy, done;

    always #5 clk = ~clk;

    logic [W-1:0] a_mem [RL];
    logic [W-1:0] b_mem [RL];
    int           a_idx, b_idx;
    logic         b_block;

    assign a_empty = (a_idx >= RL);
    assign a_data  = (a_idx < RL) ? a_mem[a_idx] : '0;
    assign b_empty = b_block || (b_idx >= RL);
    assign b_data  = (b_idx < RL) ? b_mem[b_idx] : '0;

    merge_2way #(.WIDTH(W), .RUN_LEN(RL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_empty    (a_empty),
        .a_data     (a_data),
        .a_pop_req_n(a_pop_req_n),
        .b_empty    (b_empty),
        .b_data     (b_data),
        .b_pop_req_n(b_pop_req_n),
        .out_full   (out_full),
        .push_req_n (push_req_n),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done)
    );

    int           tests = 0;
    int           fails = 0;
    int           n_push, viol, cyc, first_cyc, last_cyc, done_cyc, done_cnt, stall_push;
    logic [W-1:0] out_log [8];
    logic         src_log [8];
    logic [W-1:0] exp_out [8];
    logic         exp_src [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then apply pops to the
    // FIFO models just after the rising edge.
    task automatic step();
        logic pa, pb;
        @(negedge clk);
        cyc++;
        pa = !a_pop_req_n;
        pb = !b_pop_req_n;
        if ((pa || pb) && push_req_n)            viol++;
        if (pa && pb)                            viol++;
        if (!push_req_n && !pa && !pb)           viol++;
        if (push_req_n && (data_out != '0))      viol++;
        if (!push_req_n && out_full)             viol++;
        if ((pa && a_empty) || (pb && b_empty))  viol++;
        if (!push_req_n && b_block)              stall_push++;
        if (!push_req_n) begin
            if (n_push < 8) begin
                out_log[n_push] = data_out;
                src_log[n_push] = pa;
            end
            if (n_push == 0) first_cyc = cyc;
            last_cyc = cyc;
            n_push++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (pa) a_idx++;
        if (pb) b_idx++;
    endtask

    task automatic load(input logic [W-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
        a_mem[0] = a0; a_mem[1] = a1; a_mem[2] = a2; a_mem[3] = a3;
        b_mem[0] = b0; b_mem[1] = b1; b_mem[2] = b2; b_mem[3] = b3;
        a_idx = 0; b_idx = 0;
        n_push = 0; viol = 0; done_cnt = 0; stall_push = 0;
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
    endtask

    task automatic set_exp(input logic [W-1:0] o0, o1, o2, o3, o4, o5, o6, o7,
                           input logic [7:0] src);
        exp_out[0] = o0; exp_out[1] = o1; exp_out[2] = o2; exp_out[3] = o3;
        exp_out[4] = o4; exp_out[5] = o5; exp_out[6] = o6; exp_out[7] = o7;
        for (int i = 0; i < 8; i++) exp_src[i] = src[7-i];
    endtask

    // Start a merge and run until done, optionally stalling downstream or B.
    task automatic run(input string tag, input int full_after, input int full_len,
                       input int be_after, input int be_len);
        int full_used, be_used;
        full_used = 0;
        be_used   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        for (int k = 0; k < 40 && done_cnt == 0; k++) begin
            step();
            if (n_push == full_after && full_used < full_len) begin
                out_full = 1'b1; full_used++;
            end else begin
                out_full = 1'b0;
            end
            if (n_push == be_after && be_used < be_len) begin
                b_block = 1'b1; be_used++;
            end else begin
                b_block = 1'b0;
            end
        end
        out_full = 1'b0;
        b_block  = 1'b0;
        check({tag, "_done_seen"}, done_cnt, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_done_end"}, done, 0);
    endtask

    task automatic verify(input string tag, input int span);
        check({tag, "_npush"}, n_push, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_out%0d", tag, i), out_log[i], exp_out[i]);
            check($sformatf("%s_src%0d", tag, i), src_log[i], exp_src[i]);
        end
        check({tag, "_proto"}, viol, 0);
        check({tag, "_stallpush"}, stall_push, 0);
        check({tag, "_span"}, last_cyc - first_cyc, span);
        check({tag, "_done_lat"}, done_cyc, last_cyc + 1);
        check({tag, "_a_pops"}, a_idx, RL);
        check({tag, "_b_pops"}, b_idx, RL);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        out_full = 1'b0;
        b_block  = 1'b0;
        cyc      = 0;
        load(8'd1, 8'd4, 8'd6, 8'd9, 8'd2, 8'd3, 8'd7, 8'd8);
        #2;
        check("rst_push", push_req_n, 1);
        check("rst_apop", a_pop_req_n, 1);
        check("rst_bpop", b_pop_req_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", data_out, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("idle_nopush", n_push, 0);

        // Interleaved runs.
        load(8'd1, 8'd4, 8'd6, 8'd9, 8'd2, 8'd3, 8'd7, 8'd8);
        set_exp(8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9, 8'b1001_1001);
        run("basic", -1, 0, -1, 0);
        verify("basic", 7);

        // Equal keys come from A first.
        load(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5);
        set_exp(8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'b1111_0000);
        run("ties", -1, 0, -1, 0);
        verify("ties", 7);

        // All of A below B: A exhausts first, then B drains.
        load(8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd11, 8'd12, 8'd13);
        set_exp(8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd11, 8'd12, 8'd13, 8'b1111_0000);
        run("drain_b", -1, 0, -1, 0);
        verify("drain_b", 7);

        // Downstream full for 3 cycles after the 2nd push.
        load(8'd1, 8'd4, 8'd6, 8'd9, 8'd2, 8'd3, 8'd7, 8'd8);
        set_exp(8'd1, 8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd9, 8'b1001_1001);
        run("full", 2, 3, -1, 0);
        verify("full", 10);

        // B empty for 2 cycles after the 1st push; A must not advance alone.
        load(8'd1, 8'd4, 8'd6, 8'd9, 8'd2, 8'd3, 8'd7, 8'd8);
        run("bempty", -1, 0, 1, 2);
        verify("bempty", 9);

        // Reset after the 3rd push, then a clean restart.
        load(8'd1, 8'd4, 8'd6, 8'd9, 8'd2, 8'd3, 8'd7, 8'd8);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20 && n_push < 3; k++) step();
        check("mid_npush", n_push, 3);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_push", push_req_n, 1);
        check("mid_rst_apop", a_pop_req_n, 1);
        check("mid_rst_bpop", b_pop_req_n, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", data_out, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        check("post_rst_npush", n_push, 3);
        check("post_rst_busy", busy, 0);
        check("post_rst_proto", viol, 0);
        load(8'd1, 8'd4, 8'd6, 8'd9, 8'd2, 8'd3, 8'd7, 8'd8);
        run("restart", -1, 0, -1, 0);
        verify("restart", 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/merge_2way.md
MERGE_2WAY -- requirements
Module: merge_2way

Interface
REQ-001 Parameter: WIDTH, 8, element width in bits.
REQ-002 Parameter: RUN_LEN, 4, elements per sorted input run on each side (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins merging one run from A and one run from B.
REQ-006 a_empty  input  1  upstream FIFO A empty flag (1 = no valid head).
REQ-007 a_data  input  WIDTH  upstream FIFO A head element, valid when a_empty=0.
REQ-008 a_pop_req_n  output  1  active-low pop to FIFO A.
REQ-009 b_empty  input  1  upstream FIFO B empty flag.
REQ-010 b_data  input  WIDTH  upstream FIFO B head element, valid when b_empty=0.
REQ-011 b_pop_req_n  output  1  active-low pop to FIFO B.
REQ-012 out_full  input  1  downstream FIFO full flag.
REQ-013 push_req_n  output  1  active-low push to downstream FIFO.
REQ-014 data_out  output  WIDTH  element pushed downstream, valid when push_req_n=0.
REQ-015 busy  output  1  high from the cycle after accepted start until the done cycle, inclusive.
REQ-016 done  output  1  one-cycle pulse after the 2*RUN_LEN-th push.

Function
REQ-017 States: IDLE, MERGE, DRAIN_A, DRAIN_B, DONE; counters cnt_a, cnt_b, each $clog2(RUN_LEN+1) bits.
REQ-018 IDLE: start=1 -> MERGE, cnt_a=cnt_b=0; start is ignored in all other states.
REQ-019 Transfer condition (combinational, same cycle): source head valid and out_full=0; on transfer, push_req_n=0, the source pop_req_n=0, and data_out=source head.
REQ-020 MERGE: a transfer requires both a_empty=0 and b_empty=0; the source is A if a_data <= b_data (unsigned; ties take A, for stability), otherwise B.
REQ-021 MERGE: either head empty or out_full=1 -> no pop, no push, push_req_n=1, state held (stall, no data loss).
REQ-022 Each transfer increments the source counter by exactly 1.
REQ-023 MERGE: a transfer that makes cnt_a=RUN_LEN goes to DRAIN_B; one that makes cnt_b=RUN_LEN goes to DRAIN_A.
REQ-024 DRAIN_A: transfers from A only whenever a_empty=0 and out_full=0; b_pop_req_n stays 1.
REQ-025 DRAIN_B: the mirror of DRAIN_A for B.
REQ-026 A drain transfer that makes both counters reach RUN_LEN -> DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-027 At most one pop and one push are asserted per cycle, and a pop is never asserted without a push in the same cycle.
REQ-028 In IDLE and DONE, a_pop_req_n=b_pop_req_n=push_req_n=1; data_out=0 whenever push_req_n=1.
REQ-029 No element beyond RUN_LEN is ever popped from either side.

Reset
REQ-030 rst_n=0 asynchronously forces IDLE and cnt_a=cnt_b=0.
REQ-031 During reset: push_req_n=1, a_pop_req_n=1, b_pop_req_n=1, busy=0, done=0, data_out=0.
REQ-032 Reset mid-merge abandons the run with no further pops or pushes; a new start is required after release.

Verification
REQ-033 RUN_LEN=4, A={1,4,6,9}, B={2,3,7,8}, out_full=0, start -> pushes 1,2,3,4,6,7,8,9 on 8 consecutive cycles, done pulses on the cycle after the last push.
REQ-034 A={5,5,5,5}, B={5,5,5,5} -> the first four pops are from A (ties), then B drains; 8 pushes of 5.
REQ-035 A={1,2,3,4}, B={10,11,12,13} -> A popped 4 times, enter DRAIN_B, then 10..13 pushed; b_pop_req_n stays 1 until DRAIN_B.
REQ-036 out_full=1 for 3 cycles mid-merge -> no pop or push while full; output sequence identical to REQ-033.
REQ-037 b_empty=1 for 2 cycles during MERGE -> stall with no A pop; merge resumes correctly once B has data.
REQ-038 rst_n pulsed low after the 3rd push -> all pops and pushes deassert immediately, busy=0; start after release restarts with counters at 0.
